// File: rtl/fpu_ctrl.sv
// Issue/writeback sequencer in front of the fpu: latches one instruction, holds it until fin, registers writeback.
// Optional build macro FPU_CTRL_FWD_EN: same-cycle reissue in the writeback cycle with FP result forwarding.
module fpu_ctrl #(
    parameter int unsigned RA_W = 5
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            issue_valid,
    output logic            issue_ready,
    input  logic [3:0]      issue_op,
    input  logic [31:0]     issue_src0,
    input  logic [31:0]     issue_src1,
    input  logic [RA_W-1:0] issue_rs1,
    input  logic [RA_W-1:0] issue_rs2,
    input  logic [RA_W-1:0] issue_rd,
    output logic [3:0]      fpu_op,
    output logic [31:0]     fpu_src0,
    output logic [31:0]     fpu_src1,
    input  logic [31:0]     fpu_result,
    input  logic            fpu_fin,
    output logic            wb_valid,
    output logic [RA_W-1:0] wb_rd,
    output logic [31:0]     wb_data,
    output logic            wb_to_int,
    output logic            busy
);

    localparam int unsigned OP_W   = 4;
    localparam int unsigned DATA_W = 32;
    localparam logic [OP_W-1:0] OP_NOP = OP_W'(4'b1111);

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [OP_W-1:0]     op_q;
    logic [DATA_W-1:0]   src0_q;
    logic [DATA_W-1:0]   src1_q;
    logic [RA_W-1:0]     rd_q;
    logic                to_int_q;

    logic                accept_c;
    logic                fin_c;
    logic                ready_d;
    logic                to_int_c;
    logic [DATA_W-1:0]   src0_d;
    logic [DATA_W-1:0]   src1_d;

    // op_q returns to NOP on completion, so it directly drives fpu_op in both states
    assign fpu_op   = op_q;
    assign fpu_src0 = src0_q;
    assign fpu_src1 = src1_q;
    assign to_int_c = (issue_op[3:2] == 2'b10);

    // Next-state and handshake decode
    always_comb begin
        state_d  = state_q;
        accept_c = 1'b0;
        fin_c    = 1'b0;
        case (state_q)
            IDLE: begin
                if (issue_valid && issue_ready) begin
                    accept_c = 1'b1;
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                if (fpu_fin) begin
                    fin_c   = 1'b1;
                    state_d = IDLE;
                end
            end
        endcase
`ifdef FPU_CTRL_FWD_EN
        ready_d = (state_d == IDLE);
`else
        // One bubble after completion so the regfile write lands before operands are sampled
        ready_d = (state_d == IDLE) && !fin_c;
`endif
    end

`ifdef FPU_CTRL_FWD_EN
    logic fwd0_c;
    logic fwd1_c;

    // Bypass the FP result being written back this cycle
    always_comb begin
        fwd0_c = wb_valid && !wb_to_int && (issue_rs1 == wb_rd);
        fwd1_c = wb_valid && !wb_to_int && (issue_rs2 == wb_rd);
        src0_d = fwd0_c ? wb_data : issue_src0;
        src1_d = fwd1_c ? wb_data : issue_src1;
    end
`else
    logic unused_rs_c;

    always_comb begin
        src0_d      = issue_src0;
        src1_d      = issue_src1;
        unused_rs_c = ^{issue_rs1, issue_rs2};
    end
`endif

    // State, latched instruction and registered writeback
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= IDLE;
            issue_ready <= 1'b1;
            busy        <= 1'b0;
            op_q        <= OP_NOP;
            src0_q      <= '0;
            src1_q      <= '0;
            rd_q        <= '0;
            to_int_q    <= 1'b0;
            wb_valid    <= 1'b0;
            wb_rd       <= '0;
            wb_data     <= '0;
            wb_to_int   <= 1'b0;
        end else begin
            state_q     <= state_d;
            issue_ready <= ready_d;
            busy        <= (state_d != IDLE);
            wb_valid    <= fin_c;
            if (accept_c) begin
                op_q     <= issue_op;
                src0_q   <= src0_d;
                src1_q   <= src1_d;
                rd_q     <= issue_rd;
                to_int_q <= to_int_c;
            end
            if (fin_c) begin
                op_q      <= OP_NOP;
                wb_data   <= fpu_result;
                wb_rd     <= rd_q;
                wb_to_int <= to_int_q;
            end
        end
    end

endmodule

// File: doc/fpu_ctrl.md
# fpu_ctrl

Issue/writeback sequencer in front of `fpu`. Accepts one decoded FP instruction at a time from the execute stage and latches its opcode and operands. It holds them stable on the `fpu` inputs until `fin`, then presents a one-cycle registered writeback to the FP or integer register file. While idle it drives a NOP opcode so the `fpu` internal cycle counter stays at 0.

## Interface
Parameters:
- RA_W, default 5, register-address width

Ports:
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- issue_valid  in  1  upstream presents an instruction
- issue_ready  out  1  controller accepts this cycle
- issue_op  in  4  fpuop encoding (0000 fadd … 1100 fcvt.s.w)
- issue_src0  in  32  operand 0 (rs1 read data)
- issue_src1  in  32  operand 1 (rs2 read data)
- issue_rs1  in  RA_W  rs1 address (forwarding only)
- issue_rs2  in  RA_W  rs2 address (forwarding only)
- issue_rd  in  RA_W  destination address
- fpu_op  out  4  to fpu.fpuop
- fpu_src0  out  32  to fpu.src0
- fpu_src1  out  32  to fpu.src1
- fpu_result  in  32  from fpu.result
- fpu_fin  in  1  from fpu.fin
- wb_valid  out  1  writeback strobe, one cycle
- wb_rd  out  RA_W  writeback address
- wb_data  out  32  writeback data
- wb_to_int  out  1  1: integer regfile, 0: FP regfile
- busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, EXEC.
- IDLE:
  - fpu_op = 4'b1111 (NOP: fpu reports fin=1, counter held at 0).
  - fpu_src0 and fpu_src1 = latched values (don't-care).
  - issue_ready = 1, except as noted under Configuration.
- IDLE, on issue_valid && issue_ready:
  - Latch op_q, src0_q, src1_q, rd_q.
  - to_int_q = (op ∈ {1000,1001,1010,1011}).
  - Go to EXEC.
- EXEC:
  - fpu_op = op_q, fpu_src0 = src0_q, fpu_src1 = src1_q, all stable every cycle.
  - issue_ready = 0. issue_valid is ignored and nothing is latched.
- EXEC, on fpu_fin:
  - Register wb_data <= fpu_result, wb_rd <= rd_q, wb_to_int <= to_int_q, wb_valid <= 1.
  - Go to IDLE.
- wb_valid is high for exactly one cycle. wb_data, wb_rd and wb_to_int hold their values until the next writeback.
- Opcodes 1101–1111 are accepted. The fpu returns 0 with fin=1, so they complete as single-cycle ops with wb_data=0 and wb_to_int=0.
- No exceptions and no flags. Overflow is not reported.

## Timing
- Issue accepted at cycle T. EXEC begins at T+1. Latency from accept to wb_valid:
  - fadd, fsub, fmul: fin at T+4, wb_valid at T+5.
  - fdiv: fin at T+11, wb_valid at T+12.
  - fsqrt: fin at T+8, wb_valid at T+9.
  - fcvt.w.s, fcvt.s.w: fin at T+2, wb_valid at T+3.
  - fsgnj*, feq, fle, flt, illegal: fin at T+1, wb_valid at T+2.
- The controller re-enters IDLE in the wb_valid cycle. With forwarding, the next issue can be accepted in that same cycle.
- At most one instruction is in flight. Issue throughput is 1 per (latency) cycles.
- Reset values:
  - State IDLE, busy=0, issue_ready=1.
  - wb_valid=0, wb_data=0, wb_rd=0, wb_to_int=0.
  - op_q=1111, src0_q=0, src1_q=0, rd_q=0.
- Reset mid-EXEC: the operation is dropped and no writeback occurs. The fpu shares rstn, so its counter also clears.
- The fpu's fin is combinational on fpu_op. fpu_op must never change during EXEC. The controller meets this because it changes fpu_op only on the IDLE/EXEC transitions.

## Configuration
- Macro: FPU_CTRL_FWD_EN.
- Defined:
  - In the wb_valid cycle, issue_ready = 1.
  - If wb_valid && !wb_to_int && issue_rs1 == wb_rd, latch wb_data instead of issue_src0.
  - Likewise for rs2 and src1.
  - Register 0 is not special for FP.
- Undefined:
  - issue_ready = 0 in the wb_valid cycle, adding one bubble, so the register-file write completes before the operands are sampled.
  - issue_rs1 and issue_rs2 are unused.

## Test plan
- fadd: op=0000, src0=0x3F800000, src1=0x40000000, rd=3, accepted at T -> wb_valid only at T+5, wb_data=0x40400000, wb_rd=3, wb_to_int=0. fpu_op=0000 at T+1..T+4.
- fdiv: op=0011, src0=0x40C00000, src1=0x40000000 -> wb_valid at T+12, wb_data=0x40400000. issue_valid held high throughout sees issue_ready=0 from T+1 to T+11.
- feq: op=1000, src0=src1=0x3F800000, rd=7 -> wb_valid at T+2, wb_data=0x00000001, wb_to_int=1.
- Dependent pair with FPU_CTRL_FWD_EN:
  - fmul writes rd=5 with 0x40C00000.
  - Next fsub issued with rs1=5 and a stale issue_src0 in the wb_valid cycle -> accepted in that cycle, and fpu_src0 = 0x40C00000.
  - Without the macro, the same issue is accepted one cycle later.
- Reset mid-op: rstn=0 at T+5 of an fdiv -> wb_valid stays 0 through T+12. After reset, busy=0 and issue_ready=1; a new fadd completes at normal latency.
- Illegal op 1110 -> wb_valid at T+2, wb_data=0, wb_to_int=0.
